id_ex_forward_stage: RTL and testbench
======================================

Name: id_ex_forward_stage

Overview:
- ID/EX pipeline register plus operand forwarding for the pipelined CPU.
- Captures decoded operands and control from ID each cycle and resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Drives the ALU's two signed 32-bit operands and 4-bit op code directly.
- Detects load-use hazards and inserts a one-cycle bubble.

Parameters:
- DATA_W, 32, operand/result width
- REG_AW, 5, register-file address width

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous reset, active-low
- id_valid_i  in  1  ID slot holds a real instruction
- id_rs_data_i  in  DATA_W  register-file read data, rs
- id_rt_data_i  in  DATA_W  register-file read data, rt
- id_imm_i  in  DATA_W  sign-extended immediate
- id_rs_addr_i  in  REG_AW  rs index
- id_rt_addr_i  in  REG_AW  rt index
- id_rd_addr_i  in  REG_AW  resolved destination index
- id_alu_ctrl_i  in  4  ALU op: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 12 NOR
- id_alusrc_i  in  1  1 selects immediate as operand 2
- id_regwrite_i  in  1  instruction writes the register file
- id_memread_i  in  1  instruction is a load
- flush_i  in  1  branch-taken squash of the ID slot
- exmem_regwrite_i  in  1  EX/MEM stage writes the register file
- exmem_rd_i  in  REG_AW  EX/MEM destination index
- exmem_result_i  in  DATA_W  EX/MEM ALU result
- memwb_regwrite_i  in  1  MEM/WB stage writes the register file
- memwb_rd_i  in  REG_AW  MEM/WB destination index
- memwb_data_i  in  DATA_W  MEM/WB writeback data
- src1_o  out  DATA_W  ALU operand 1 (forwarded rs)
- src2_o  out  DATA_W  ALU operand 2 (immediate or forwarded rt)
- ctrl_o  out  4  ALU op code
- ex_store_data_o  out  DATA_W  forwarded rt, for stores
- ex_valid_o  out  1  EX slot valid
- ex_rd_o  out  REG_AW  EX destination index
- ex_regwrite_o  out  1  EX regwrite, gated by valid
- ex_memread_o  out  1  EX memread, gated by valid
- load_use_stall_o  out  1  hold PC and IF/ID this cycle

Behaviour:

Reset:
- rst_i low clears all registered state asynchronously: valid, rd, ctrl, regwrite, memread, alusrc, stored operands, immediate, rs/rt indices.
- Forwarded outputs therefore read 0 during reset; load_use_stall_o reads 0.

Load-use detection (combinational):
- load_use_stall_o = id_valid_i & ex_valid_o & ex_memread_o & (ex_rd_o != 0) & (ex_rd_o == id_rs_addr_i | (ex_rd_o == id_rt_addr_i & !id_alusrc_i)).

Register capture (rising edge):
- If flush_i or load_use_stall_o: load a bubble. Valid, regwrite and memread are 0; ctrl is 0; data fields don't-care but deterministic (cleared).
- flush_i takes priority; simultaneous flush + stall yields one bubble.
- Otherwise capture all id_* fields; valid = id_valid_i.
- Regwrite and memread are stored ANDed with id_valid_i.

Forwarding (combinational, on registered rs/rt):
- Per operand, priority order:
  1. EX/MEM, if exmem_regwrite_i, exmem_rd_i != 0 and index matches.
  2. Else MEM/WB, if memwb_regwrite_i, memwb_rd_i != 0 and index matches.
  3. Else the registered register-file data.
- Register 0 is never forwarded.

Outputs:
- src1_o = forwarded rs.
- src2_o = stored immediate if alusrc, else forwarded rt.
- ex_store_data_o = forwarded rt regardless of alusrc.
- Latency: ID inputs appear at EX outputs one cycle after the capturing edge; no other added latency.
- Bubble guarantee: a bubble produces no architectural effect downstream, since ex_regwrite_o = ex_memread_o = 0.

Test Plan:
1. Reset and stall: rst_i low mid-operation with valid instruction loaded -> all outputs 0 immediately (no clock edge needed); load_use_stall_o = 0.
2. EX/MEM forwarding: EX `add r3` with exmem_result_i = 0x0000_0010; ID-captured rs = r3, stale rs data 0x5 -> src1_o = 0x10. Same case with exmem_rd_i = 0 and regwrite = 1 -> src1_o = 0x5.
3. Double hazard: exmem and memwb both target r4 (0x11 and 0x22) -> src2_o = 0x11. Drop exmem_regwrite_i -> src2_o = 0x22.
4. Load-use: EX `lw r5` (memread = 1), ID uses rs = r5 -> load_use_stall_o = 1. Next edge, ex_valid_o = 0 and ex_regwrite_o = 0. ID held one cycle then captured; with alusrc = 1 and only rt = r5, no stall.
5. Flush vs stall: flush_i = 1 together with a load-use condition -> exactly one bubble. Next unflushed instruction captured on the following edge.
6. Immediate select: alusrc = 1, imm = 0xFFFF_FFFC, rt forwarded = 0x7 -> src2_o = 0xFFFF_FFFC; ex_store_data_o = 0x7.

Source files
------------

// File: rtl/id_ex_forward_stage_if.sv
// Bundle of ID-side, forwarding-source and EX-side signals around the ID/EX register.
// The stage itself uses the slave modport; whoever drives ID and observes EX uses master.
interface id_ex_forward_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
);
    logic              id_valid_i;
    logic [DATA_W-1:0] id_rs_data_i;
    logic [DATA_W-1:0] id_rt_data_i;
    logic [DATA_W-1:0] id_imm_i;
    logic [REG_AW-1:0] id_rs_addr_i;
    logic [REG_AW-1:0] id_rt_addr_i;
    logic [REG_AW-1:0] id_rd_addr_i;
    logic [3:0]        id_alu_ctrl_i;
    logic              id_alusrc_i;
    logic              id_regwrite_i;
    logic              id_memread_i;
    logic              flush_i;
    logic              exmem_regwrite_i;
    logic [REG_AW-1:0] exmem_rd_i;
    logic [DATA_W-1:0] exmem_result_i;
    logic              memwb_regwrite_i;
    logic [REG_AW-1:0] memwb_rd_i;
    logic [DATA_W-1:0] memwb_data_i;
    logic [DATA_W-1:0] src1_o;
    logic [DATA_W-1:0] src2_o;
    logic [3:0]        ctrl_o;
    logic [DATA_W-1:0] ex_store_data_o;
    logic              ex_valid_o;
    logic [REG_AW-1:0] ex_rd_o;
    logic              ex_regwrite_o;
    logic              ex_memread_o;
    logic              load_use_stall_o;

    modport master (
        output id_valid_i, id_rs_data_i, id_rt_data_i, id_imm_i, id_rs_addr_i, id_rt_addr_i,
               id_rd_addr_i, id_alu_ctrl_i, id_alusrc_i, id_regwrite_i, id_memread_i, flush_i,
               exmem_regwrite_i, exmem_rd_i, exmem_result_i,
               memwb_regwrite_i, memwb_rd_i, memwb_data_i,
        input  src1_o, src2_o, ctrl_o, ex_store_data_o, ex_valid_o, ex_rd_o, ex_regwrite_o,
               ex_memread_o, load_use_stall_o
    );

    modport slave (
        input  id_valid_i, id_rs_data_i, id_rt_data_i, id_imm_i, id_rs_addr_i, id_rt_addr_i,
               id_rd_addr_i, id_alu_ctrl_i, id_alusrc_i, id_regwrite_i, id_memread_i, flush_i,
               exmem_regwrite_i, exmem_rd_i, exmem_result_i,
               memwb_regwrite_i, memwb_rd_i, memwb_data_i,
        output src1_o, src2_o, ctrl_o, ex_store_data_o, ex_valid_o, ex_rd_o, ex_regwrite_o,
               ex_memread_o, load_use_stall_o
    );
endinterface

// File: rtl/id_ex_forward_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and load-use bubbling.
// Forwarding is resolved on the registered rs/rt indices, so the ALU sees operands directly.
module id_ex_forward_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input logic                  clk_i,
    input logic                  rst_i,
    id_ex_forward_stage_if.slave bus
);
    logic              ex_valid_q;
    logic              regwrite_q;
    logic              memread_q;
    logic              alusrc_q;
    logic [REG_AW-1:0] rd_q;
    logic [REG_AW-1:0] rs_addr_q;
    logic [REG_AW-1:0] rt_addr_q;
    logic [3:0]        ctrl_q;
    logic [DATA_W-1:0] rs_data_q;
    logic [DATA_W-1:0] rt_data_q;
    logic [DATA_W-1:0] imm_q;

    logic              load_use;
    logic              bubble;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    // rt only matters for the hazard when it is actually read as an ALU operand
    always_comb begin
        load_use = bus.id_valid_i & ex_valid_q & memread_q & (rd_q != '0) &
                   ((rd_q == bus.id_rs_addr_i) |
                    ((rd_q == bus.id_rt_addr_i) & ~bus.id_alusrc_i));
        bubble   = bus.flush_i | load_use;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_valid_q <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            alusrc_q   <= 1'b0;
            rd_q       <= '0;
            rs_addr_q  <= '0;
            rt_addr_q  <= '0;
            ctrl_q     <= 4'd0;
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            imm_q      <= '0;
        end else if (bubble) begin
            ex_valid_q <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            alusrc_q   <= 1'b0;
            rd_q       <= '0;
            rs_addr_q  <= '0;
            rt_addr_q  <= '0;
            ctrl_q     <= 4'd0;
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            imm_q      <= '0;
        end else begin
            ex_valid_q <= bus.id_valid_i;
            regwrite_q <= bus.id_regwrite_i & bus.id_valid_i;
            memread_q  <= bus.id_memread_i & bus.id_valid_i;
            alusrc_q   <= bus.id_alusrc_i;
            rd_q       <= bus.id_rd_addr_i;
            rs_addr_q  <= bus.id_rs_addr_i;
            rt_addr_q  <= bus.id_rt_addr_i;
            ctrl_q     <= bus.id_alu_ctrl_i;
            rs_data_q  <= bus.id_rs_data_i;
            rt_data_q  <= bus.id_rt_data_i;
            imm_q      <= bus.id_imm_i;
        end
    end

    // Youngest producer wins; r0 is hardwired so it is never forwarded
    always_comb begin
        fwd_rs = rs_data_q;
        if (bus.exmem_regwrite_i && (bus.exmem_rd_i != '0) && (bus.exmem_rd_i == rs_addr_q)) begin
            fwd_rs = bus.exmem_result_i;
        end else if (bus.memwb_regwrite_i && (bus.memwb_rd_i != '0) &&
                     (bus.memwb_rd_i == rs_addr_q)) begin
            fwd_rs = bus.memwb_data_i;
        end

        fwd_rt = rt_data_q;
        if (bus.exmem_regwrite_i && (bus.exmem_rd_i != '0) && (bus.exmem_rd_i == rt_addr_q)) begin
            fwd_rt = bus.exmem_result_i;
        end else if (bus.memwb_regwrite_i && (bus.memwb_rd_i != '0) &&
                     (bus.memwb_rd_i == rt_addr_q)) begin
            fwd_rt = bus.memwb_data_i;
        end
    end

    assign bus.src1_o           = fwd_rs;
    assign bus.src2_o           = alusrc_q ? imm_q : fwd_rt;
    assign bus.ex_store_data_o  = fwd_rt;
    assign bus.ctrl_o           = ctrl_q;
    assign bus.ex_valid_o       = ex_valid_q;
    assign bus.ex_rd_o          = rd_q;
    assign bus.ex_regwrite_o    = regwrite_q & ex_valid_q;
    assign bus.ex_memread_o     = memread_q & ex_valid_q;
    assign bus.load_use_stall_o = load_use;
endmodule

// File: tb/tb_id_ex_forward_stage.sv
// Self-checking bench for id_ex_forward_stage: directed scenarios plus randomized traffic
// checked against an instruction-level model of the EX slot and the forwarding producers.
module tb_id_ex_forward_stage;
    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    id_ex_forward_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

    id_ex_forward_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic        valid;
        logic        rw;
        logic        mr;
        logic        alusrc;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [3:0]  ctrl;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [31:0] imm;
    } slot_t;

    typedef struct packed {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] data;
    } prod_t;

    slot_t m;  // instruction the model believes sits in EX

    // Value an EX instruction should see for register idx: youngest writer in flight, else its own
    function automatic logic [31:0] exp_fwd(input logic [4:0] idx, input logic [31:0] own);
        prod_t q[$];
        q.push_back({bus.exmem_regwrite_i, bus.exmem_rd_i, bus.exmem_result_i});
        q.push_back({bus.memwb_regwrite_i, bus.memwb_rd_i, bus.memwb_data_i});
        foreach (q[i]) if (q[i].rw && q[i].rd != 0 && q[i].rd == idx) return q[i].data;
        return own;
    endfunction

    // A load in EX whose result the ID instruction reads cannot be forwarded in time
    function automatic logic model_stall();
        logic reads_rt;
        reads_rt = !bus.id_alusrc_i && bus.id_rt_addr_i == m.rd;
        return bus.id_valid_i && m.valid && m.mr && m.rd != 0 &&
               (bus.id_rs_addr_i == m.rd || reads_rt);
    endfunction

    task automatic step();
        logic bub;
        bub = bus.flush_i | model_stall();
        @(posedge clk);
        if (bub) m = '0;
        else begin
            m.valid  = bus.id_valid_i;
            m.rw     = bus.id_regwrite_i & bus.id_valid_i;
            m.mr     = bus.id_memread_i & bus.id_valid_i;
            m.alusrc = bus.id_alusrc_i;
            m.rd     = bus.id_rd_addr_i;
            m.rs     = bus.id_rs_addr_i;
            m.rt     = bus.id_rt_addr_i;
            m.ctrl   = bus.id_alu_ctrl_i;
            m.rsd    = bus.id_rs_data_i;
            m.rtd    = bus.id_rt_data_i;
            m.imm    = bus.id_imm_i;
        end
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                            input logic [31:0] imm, input logic [3:0] ctrl, input logic alusrc,
                            input logic rw, input logic mr);
        bus.id_valid_i    = v;
        bus.id_rs_addr_i  = rs;
        bus.id_rt_addr_i  = rt;
        bus.id_rd_addr_i  = rd;
        bus.id_rs_data_i  = rsd;
        bus.id_rt_data_i  = rtd;
        bus.id_imm_i      = imm;
        bus.id_alu_ctrl_i = ctrl;
        bus.id_alusrc_i   = alusrc;
        bus.id_regwrite_i = rw;
        bus.id_memread_i  = mr;
    endtask

    task automatic clear_fwd();
        bus.flush_i          = 1'b0;
        bus.exmem_regwrite_i = 1'b0;
        bus.exmem_rd_i       = '0;
        bus.exmem_result_i   = '0;
        bus.memwb_regwrite_i = 1'b0;
        bus.memwb_rd_i       = '0;
        bus.memwb_data_i     = '0;
    endtask

    task automatic test_reset();
        logic [136:0] all_out;
        all_out = {bus.src1_o, bus.src2_o, bus.ctrl_o, bus.ex_store_data_o, bus.ex_valid_o,
                   bus.ex_rd_o, bus.ex_regwrite_o, bus.ex_memread_o, bus.load_use_stall_o};
        vectors++;
        if (all_out !== '0) begin
            miscompares++;
            $display("FAIL reset_initial: got %h, expected 0", all_out);
        end
        // load r3 into EX, then an ID consumer of r3 so a stall is pending
        drive_id(1, 5'd2, 5'd0, 5'd3, 32'hAA, 32'h0, 32'h0, 4'd2, 0, 1, 1);
        step();
        drive_id(1, 5'd3, 5'd0, 5'd4, 32'h1, 32'h0, 32'h0, 4'd2, 0, 1, 0);
        #1;
        vectors++;
        if (bus.load_use_stall_o !== 1'b1 || bus.ex_valid_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_preload: got stall=%b valid=%b, expected 1 1",
                     bus.load_use_stall_o, bus.ex_valid_o);
        end
        #1 rst_n = 1'b0;
        #1;
        all_out = {bus.src1_o, bus.src2_o, bus.ctrl_o, bus.ex_store_data_o, bus.ex_valid_o,
                   bus.ex_rd_o, bus.ex_regwrite_o, bus.ex_memread_o, bus.load_use_stall_o};
        vectors++;
        if (all_out !== '0) begin
            miscompares++;
            $display("FAIL reset_async: got %h, expected 0", all_out);
        end
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        m = '0;
        #1 rst_n = 1'b1;
        step();
    endtask

    task automatic test_exmem_fwd();
        drive_id(1, 5'd3, 5'd0, 5'd8, 32'h5, 32'h0, 32'h0, 4'd2, 0, 1, 0);
        step();
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.exmem_regwrite_i = 1; bus.exmem_rd_i = 5'd3; bus.exmem_result_i = 32'h10;
        #1;
        vectors++;
        if (bus.src1_o !== 32'h10) begin
            miscompares++;
            $display("FAIL exmem_fwd: got %h, expected %h", bus.src1_o, 32'h10);
        end
        bus.exmem_rd_i = 5'd0;
        #1;
        vectors++;
        if (bus.src1_o !== 32'h5) begin
            miscompares++;
            $display("FAIL exmem_r0_nofwd: got %h, expected %h", bus.src1_o, 32'h5);
        end
        clear_fwd();
    endtask

    task automatic test_double_hazard();
        drive_id(1, 5'd1, 5'd4, 5'd9, 32'h0, 32'h33, 32'h0, 4'd6, 0, 1, 0);
        step();
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.exmem_regwrite_i = 1; bus.exmem_rd_i = 5'd4; bus.exmem_result_i = 32'h11;
        bus.memwb_regwrite_i = 1; bus.memwb_rd_i = 5'd4; bus.memwb_data_i   = 32'h22;
        #1;
        vectors++;
        if (bus.src2_o !== 32'h11) begin
            miscompares++;
            $display("FAIL double_hazard_exmem: got %h, expected %h", bus.src2_o, 32'h11);
        end
        bus.exmem_regwrite_i = 0;
        #1;
        vectors++;
        if (bus.src2_o !== 32'h22) begin
            miscompares++;
            $display("FAIL double_hazard_memwb: got %h, expected %h", bus.src2_o, 32'h22);
        end
        clear_fwd();
    endtask

    task automatic test_load_use();
        drive_id(1, 5'd1, 5'd2, 5'd5, 32'h0, 32'h0, 32'h4, 4'd2, 1, 1, 1);  // lw r5
        step();
        drive_id(1, 5'd5, 5'd0, 5'd7, 32'h77, 32'h0, 32'h0, 4'd2, 0, 1, 0);
        #1;
        vectors++;
        if (bus.load_use_stall_o !== 1'b1) begin
            miscompares++;
            $display("FAIL load_use_stall: got %b, expected 1", bus.load_use_stall_o);
        end
        step();
        vectors++;
        if (bus.ex_valid_o !== 1'b0 || bus.ex_regwrite_o !== 1'b0) begin
            miscompares++;
            $display("FAIL load_use_bubble: got valid=%b rw=%b, expected 0 0",
                     bus.ex_valid_o, bus.ex_regwrite_o);
        end
        step();  // held instruction now captured
        vectors++;
        if (bus.ex_valid_o !== 1'b1 || bus.ex_rd_o !== 5'd7) begin
            miscompares++;
            $display("FAIL load_use_release: got valid=%b rd=%0d, expected 1 7",
                     bus.ex_valid_o, bus.ex_rd_o);
        end
        drive_id(1, 5'd1, 5'd2, 5'd5, 32'h0, 32'h0, 32'h4, 4'd2, 1, 1, 1);
        step();
        drive_id(1, 5'd1, 5'd5, 5'd6, 32'h0, 32'h0, 32'h8, 4'd2, 1, 1, 0);
        #1;
        vectors++;
        if (bus.load_use_stall_o !== 1'b0) begin
            miscompares++;
            $display("FAIL load_use_imm_nostall: got %b, expected 0", bus.load_use_stall_o);
        end
        step();
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_flush_vs_stall();
        drive_id(1, 5'd1, 5'd2, 5'd6, 32'h0, 32'h0, 32'h4, 4'd2, 1, 1, 1);  // lw r6
        step();
        drive_id(1, 5'd6, 5'd0, 5'd8, 32'h0, 32'h0, 32'h0, 4'd2, 0, 1, 0);
        bus.flush_i = 1'b1;
        step();
        vectors++;
        if (bus.ex_valid_o !== 1'b0 || bus.ex_regwrite_o !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_bubble: got valid=%b rw=%b, expected 0 0",
                     bus.ex_valid_o, bus.ex_regwrite_o);
        end
        bus.flush_i = 1'b0;
        drive_id(1, 5'd6, 5'd0, 5'd9, 32'h0, 32'h0, 32'h0, 4'd1, 0, 1, 0);
        step();
        vectors++;
        if (bus.ex_valid_o !== 1'b1 || bus.ex_rd_o !== 5'd9 || bus.ctrl_o !== 4'd1) begin
            miscompares++;
            $display("FAIL flush_next_capture: got valid=%b rd=%0d ctrl=%0d, expected 1 9 1",
                     bus.ex_valid_o, bus.ex_rd_o, bus.ctrl_o);
        end
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_imm_select();
        drive_id(1, 5'd1, 5'd7, 5'd2, 32'h0, 32'h1, 32'hFFFF_FFFC, 4'd2, 1, 1, 0);
        step();
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.memwb_regwrite_i = 1; bus.memwb_rd_i = 5'd7; bus.memwb_data_i = 32'h7;
        #1;
        vectors++;
        if (bus.src2_o !== 32'hFFFF_FFFC) begin
            miscompares++;
            $display("FAIL imm_src2: got %h, expected %h", bus.src2_o, 32'hFFFF_FFFC);
        end
        vectors++;
        if (bus.ex_store_data_o !== 32'h7) begin
            miscompares++;
            $display("FAIL imm_store_data: got %h, expected %h", bus.ex_store_data_o, 32'h7);
        end
        clear_fwd();
    endtask

    task automatic test_random();
        logic [31:0] e_store;
        logic [31:0] e_src1;
        logic [31:0] e_src2;
        for (int i = 0; i < 400; i++) begin
            drive_id(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom,
                     $urandom, 4'($urandom), 1'($urandom), 1'($urandom),
                     1'($urandom_range(0, 2) == 0));
            bus.flush_i          = 1'($urandom_range(0, 7) == 0);
            bus.exmem_regwrite_i = 1'($urandom);
            bus.exmem_rd_i       = 5'($urandom_range(0, 7));
            bus.exmem_result_i   = $urandom;
            bus.memwb_regwrite_i = 1'($urandom);
            bus.memwb_rd_i       = 5'($urandom_range(0, 7));
            bus.memwb_data_i     = $urandom;
            #1;
            e_src1  = exp_fwd(m.rs, m.rsd);
            e_store = exp_fwd(m.rt, m.rtd);
            e_src2  = m.alusrc ? m.imm : e_store;
            vectors++;
            if (bus.src1_o !== e_src1) begin
                miscompares++;
                $display("FAIL rand_src1[%0d]: got %h, expected %h", i, bus.src1_o, e_src1);
            end
            vectors++;
            if (bus.src2_o !== e_src2) begin
                miscompares++;
                $display("FAIL rand_src2[%0d]: got %h, expected %h", i, bus.src2_o, e_src2);
            end
            vectors++;
            if (bus.ex_store_data_o !== e_store) begin
                miscompares++;
                $display("FAIL rand_store[%0d]: got %h, expected %h", i, bus.ex_store_data_o,
                         e_store);
            end
            vectors++;
            if ({bus.ex_valid_o, bus.ex_rd_o, bus.ctrl_o} !== {m.valid, m.rd, m.ctrl}) begin
                miscompares++;
                $display("FAIL rand_slot[%0d]: got v=%b rd=%0d ctrl=%0d, expected %b %0d %0d",
                         i, bus.ex_valid_o, bus.ex_rd_o, bus.ctrl_o, m.valid, m.rd, m.ctrl);
            end
            vectors++;
            if ({bus.ex_regwrite_o, bus.ex_memread_o} !== {m.rw, m.mr}) begin
                miscompares++;
                $display("FAIL rand_ctl[%0d]: got rw=%b mr=%b, expected %b %b", i,
                         bus.ex_regwrite_o, bus.ex_memread_o, m.rw, m.mr);
            end
            vectors++;
            if (bus.load_use_stall_o !== model_stall()) begin
                miscompares++;
                $display("FAIL rand_stall[%0d]: got %b, expected %b", i, bus.load_use_stall_o,
                         model_stall());
            end
            step();
        end
        clear_fwd();
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        m     = '0;
        clear_fwd();
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_exmem_fwd();
        test_double_hazard();
        test_load_use();
        test_flush_vs_stall();
        test_imm_select();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
